// File: rtl/btn_event_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | btn_event_arbiter                                                          |
// | Synchronizes and debounces N button inputs, then serializes each press    |
// | as an event on a valid/ready port using round-robin arbitration.          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+

module btn_event_arbiter #(
  parameter  int N               = 4,
  parameter  int DEBOUNCE_CYCLES = 16,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES),
  localparam int ID_W            = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    btn_in,
  output logic [N-1:0]    btn_level,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  input  logic            evt_ready,
  output logic            overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    s1_q, s2_q;
  logic [N-1:0]    level_q, level_d;
  logic [N-1:0]    pending_q, pending_d;
  logic            valid_q, valid_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] last_q, last_d;
  logic            ovf_q, ovf_d;

  logic [N-1:0]    press;
  logic [N-1:0]    clr;
  logic [ID_W-1:0] sel;
  logic [ID_W-1:0] scan_idx;
  logic            found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= btn_in;
      s2_q <= s1_q;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic             differs;

    assign differs = (s2_q[i] != level_q[i]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (!differs || cnt_q == CNT_MAX) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign level_d[i] = (differs && cnt_q == CNT_MAX) ? s2_q[i] : level_q[i];
  end

  // A press is the cycle in which the debounced level is about to rise.
  assign press     = level_d & ~level_q;
  assign pending_d = (pending_q & ~clr) | press;
  assign ovf_d     = |(press & pending_q & ~clr);

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    id_d     = id_q;
    last_d   = last_q;
    clr      = '0;
    sel      = '0;
    scan_idx = '0;
    found    = 1'b0;

    // Scan starts just after the last served channel, wrapping modulo N.
    for (int k = 1; k <= N; k++) begin
      scan_idx = ID_W'((int'(last_q) + k) % N);
      if (!found && pending_q[scan_idx]) begin
        sel   = scan_idx;
        found = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          id_d    = sel;
          valid_d = 1'b1;
          clr     = N'(1) << sel;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (evt_ready) begin
          valid_d = 1'b0;
          last_d  = id_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      level_q   <= '0;
      pending_q <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      last_q    <= LAST_RST;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      last_q    <= last_d;
      ovf_q     <= ovf_d;
    end
  end

  assign btn_level = level_q;
  assign evt_valid = valid_q;
  assign evt_id    = id_q;
  assign overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_btn_event_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_btn_event_arbiter                                                       |
// | Directed self-checking bench for btn_event_arbiter (N=4, debounce=4).     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+

module tb_btn_event_arbiter;

  localparam int N  = 4;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_in = 4'h0;
  logic       evt_ready = 1'b0;
  logic [3:0] btn_level;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  int hs_cnt[4] = '{default: 0};
  int hs_total  = 0;
  int ovf_cnt   = 0;
  int hs_log[$];

  btn_event_arbiter #(
    .N              (N),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_in   (btn_in),
    .btn_level(btn_level),
    .evt_valid(evt_valid),
    .evt_id   (evt_id),
    .evt_ready(evt_ready),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Handshake and overflow log, sampled at the active edge.
  always @(posedge clk) begin
    if (evt_valid && evt_ready) begin
      hs_cnt[evt_id] = hs_cnt[evt_id] + 1;
      hs_total       = hs_total + 1;
      hs_log.push_back(int'(evt_id));
    end
    if (overflow) ovf_cnt = ovf_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic quiet(input int n, output int busy);
    busy = 0;
    repeat (n) begin
      tick(1);
      if (evt_valid !== 1'b0 || overflow !== 1'b0) busy++;
    end
  endtask

  initial begin
    int n;
    int base;
    int b1;
    int b2;
    int bo;

    // Reset with inputs active
    rst_n     = 1'b0;
    btn_in    = 4'hA;
    evt_ready = 1'b0;
    tick(3);
    chk("rst_level", 32'(btn_level), 32'h0);
    chk("rst_valid", 32'(evt_valid), 32'h0);
    chk("rst_id",    32'(evt_id),    32'h0);
    chk("rst_ovf",   32'(overflow),  32'h0);
    btn_in = 4'h0;
    tick(2);
    rst_n = 1'b1;
    quiet(20, n);
    chk("idle_quiet", 32'(n), 32'h0);
    chk("idle_level", 32'(btn_level), 32'h0);

    // Round-robin from reset pointer: 0, 2, 3
    evt_ready = 1'b1;
    base      = hs_log.size();
    btn_in    = 4'b1101;
    tick(6);
    chk("rr_level_e5", 32'(btn_level), 32'hD);
    chk("rr_valid_e5", 32'(evt_valid), 32'h0);
    tick(1);
    chk("rr_valid_e6", 32'(evt_valid), 32'h1);
    chk("rr_id_e6",    32'(evt_id),    32'h0);
    tick(2);
    chk("rr_id_e8",    32'(evt_id),    32'h2);
    tick(2);
    chk("rr_id_e10",   32'(evt_id),    32'h3);
    tick(2);
    chk("rr_valid_e12", 32'(evt_valid), 32'h0);
    chk("rr_count", 32'(hs_log.size() - base), 32'h3);
    chk("rr_first",  32'(hs_log[base]),     32'h0);
    chk("rr_second", 32'(hs_log[base + 1]), 32'h2);
    chk("rr_third",  32'(hs_log[base + 2]), 32'h3);
    btn_in = 4'h0;
    tick(8);
    chk("rr_release_level", 32'(btn_level), 32'h0);

    // Last served was 3, so channel 0 wins over 3
    base   = hs_log.size();
    btn_in = 4'b1001;
    tick(12);
    chk("rr2_count",  32'(hs_log.size() - base), 32'h2);
    chk("rr2_first",  32'(hs_log[base]),     32'h0);
    chk("rr2_second", 32'(hs_log[base + 1]), 32'h3);
    btn_in = 4'h0;
    tick(8);

    // Single press on channel 1
    btn_in = 4'b0010;
    tick(5);
    chk("sp_level_e4", 32'(btn_level), 32'h0);
    tick(1);
    chk("sp_level_e5", 32'(btn_level), 32'h2);
    chk("sp_valid_e5", 32'(evt_valid), 32'h0);
    tick(1);
    chk("sp_valid_e6", 32'(evt_valid), 32'h1);
    chk("sp_id_e6",    32'(evt_id),    32'h1);
    tick(1);
    chk("sp_valid_e7", 32'(evt_valid), 32'h0);
    btn_in = 4'h0;
    quiet(12, n);
    chk("sp_release_quiet", 32'(n), 32'h0);
    chk("sp_release_level", 32'(btn_level), 32'h0);

    // Bounce on channel 2: 3 high, 1 low, then steady high
    base   = hs_total;
    b2     = hs_cnt[2];
    btn_in = 4'b0100;
    tick(3);
    btn_in = 4'b0000;
    tick(1);
    btn_in = 4'b0100;
    tick(5);
    chk("bn_level_e8", 32'(btn_level), 32'h0);
    chk("bn_no_early_evt", 32'(hs_total - base), 32'h0);
    tick(1);
    chk("bn_level_e9", 32'(btn_level), 32'h4);
    tick(3);
    chk("bn_total", 32'(hs_total - base), 32'h1);
    chk("bn_ch2",   32'(hs_cnt[2] - b2),  32'h1);
    btn_in = 4'h0;
    tick(8);

    // Backpressure and overflow on channel 1
    evt_ready = 1'b0;
    b1        = hs_cnt[1];
    bo        = ovf_cnt;
    btn_in    = 4'b0010;
    tick(7);
    chk("bp_valid", 32'(evt_valid), 32'h1);
    chk("bp_id",    32'(evt_id),    32'h1);
    n = 0;
    repeat (30) begin
      tick(1);
      if (evt_valid === 1'b1 && evt_id === 2'd1) n++;
    end
    chk("bp_hold30", 32'(n), 32'd30);
    btn_in = 4'h0;
    tick(8);
    btn_in = 4'b0010;
    tick(8);
    chk("bp_second_no_ovf", 32'(ovf_cnt - bo), 32'h0);
    btn_in = 4'h0;
    tick(8);
    btn_in = 4'b0010;
    tick(5);
    chk("bp_ovf_e4", 32'(overflow), 32'h0);
    tick(1);
    chk("bp_ovf_e5", 32'(overflow), 32'h1);
    tick(1);
    chk("bp_ovf_e6", 32'(overflow), 32'h0);
    chk("bp_ovf_count", 32'(ovf_cnt - bo), 32'h1);
    chk("bp_still_valid", 32'(evt_valid), 32'h1);
    chk("bp_still_id",    32'(evt_id),    32'h1);
    evt_ready = 1'b1;
    tick(6);
    chk("bp_ch1_events", 32'(hs_cnt[1] - b1), 32'h2);
    chk("bp_drained",    32'(evt_valid),      32'h0);
    btn_in = 4'h0;
    tick(8);

    // Reset while offering channel 3 with channel 3 pending again
    evt_ready = 1'b0;
    btn_in    = 4'b1000;
    tick(7);
    chk("rmo_valid", 32'(evt_valid), 32'h1);
    chk("rmo_id",    32'(evt_id),    32'h3);
    btn_in = 4'h0;
    tick(8);
    btn_in = 4'b1000;
    tick(8);
    btn_in = 4'h0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmo_async_valid", 32'(evt_valid), 32'h0);
    tick(2);
    rst_n     = 1'b1;
    evt_ready = 1'b1;
    base      = hs_total;
    quiet(20, n);
    chk("rmo_quiet",     32'(n), 32'h0);
    chk("rmo_no_events", 32'(hs_total - base), 32'h0);
    chk("rmo_level",     32'(btn_level), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
